// File: rtl/io_arb_pkg.sv
// Shared types and constants for the output-port write arbiter.
package io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ACK
  } arb_state_e;

  localparam logic [7:0]  IO0_ADDR        = 8'h00;
  localparam logic [7:0]  IO1_ADDR        = 8'h01;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/io_rr_pick.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
module io_rr_pick (
  input  logic [1:0] eligible_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |eligible_i;
    grant_idx_o   = eligible_i[1];
    if (&eligible_i) begin
      grant_idx_o = ~last_grant_i;
    end
  end

endmodule

// File: rtl/io_write_arbiter.sv
// Arbitrates two requesters onto the IO holding-register write path with a
// one-cycle strobe per grant and a four-phase req/ack close with timeout.
module io_write_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned AW       = 8,
  parameter int unsigned IO_PORTS = 2,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] data0,
  output logic          ack0,
  output logic          err0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] data1,
  output logic          ack1,
  output logic          err1,
  output logic [AW-1:0] io_address,
  output logic [DW-1:0] io_data,
  output logic          io_writemem,
  output logic          busy,
  output logic          owner
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [1:0]    ack_q, ack_d, err_q, err_d, mask_q, mask_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wm_q, wm_d, busy_q, busy_d;
  logic          owner_q, owner_d, last_q, last_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [1:0]    req_v, eligible;
  logic          grant_valid, grant_idx;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign req_v    = {req1, req0};
  assign eligible = req_v & ~mask_q;
  assign sel_addr = grant_idx ? addr1 : addr0;
  assign sel_data = grant_idx ? data1 : data0;

  io_rr_pick u_pick (
    .eligible_i    (eligible),
    .last_grant_i  (last_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    err_d   = '0;
    wm_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // A mask only survives while its request stays high.
    mask_d  = mask_q & req_v;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          last_d  = grant_idx;
          addr_d  = sel_addr;
          data_d  = sel_data;
          cnt_d   = '0;
          if (32'(sel_addr) < IO_PORTS) begin
            state_d = WRITE;
            wm_d    = 1'b1;
          end else begin
            state_d          = ACK;
            ack_d[grant_idx] = 1'b1;
            err_d[grant_idx] = 1'b1;
          end
        end
      end
      WRITE: begin
        state_d        = ACK;
        ack_d[owner_q] = 1'b1;
      end
      ACK: begin
        if (!req_v[owner_q]) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          mask_d[owner_q] = 1'b1;
        end else begin
          cnt_d          = cnt_q + 8'd1;
          ack_d[owner_q] = 1'b1;
          err_d[owner_q] = err_q[owner_q];
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ack_q   <= '0;
      err_q   <= '0;
      mask_q  <= '0;
      wm_q    <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
      wm_q    <= wm_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ack0        = ack_q[0];
  assign ack1        = ack_q[1];
  assign err0        = err_q[0];
  assign err1        = err_q[1];
  assign io_address  = addr_q;
  assign io_data     = data_q;
  assign io_writemem = wm_q;
  assign busy        = busy_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_io_write_arbiter.sv
// Randomized and directed bench for io_write_arbiter against a transfer-level model.
module tb_io_write_arbiter;

  localparam int TIMEOUT  = 15;
  localparam int IO_PORTS = 2;

  logic       clk, reset;
  logic       req0, req1, ack0, ack1, err0, err1;
  logic [7:0] addr0, addr1, data0, data1, io_address, io_data;
  logic       io_writemem, busy, owner;

  int vectors, miscompares;

  io_write_arbiter #(.DW(8), .AW(8), .IO_PORTS(IO_PORTS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
    .io_address(io_address), .io_data(io_data), .io_writemem(io_writemem),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level model: m_own is the requester being served (-1 = none),
  // m_age counts cycles since its grant edge.
  int         m_own, m_age, m_last;
  bit         m_inv, m_owner;
  bit   [1:0] m_mask;
  logic [7:0] m_addr, m_data;

  always @(posedge clk or negedge reset) begin
    bit [1:0] r, e;
    int ackc, g;
    if (!reset) begin
      m_own = -1; m_age = 0; m_last = 1; m_inv = 0; m_owner = 0;
      m_mask = '0; m_addr = '0; m_data = '0;
    end else begin
      r = {req1, req0};
      e = r & ~m_mask;
      if (m_own >= 0) begin
        ackc = m_inv ? m_age + 1 : m_age;
        if (ackc == 0) m_age++;
        else if (!r[m_own]) m_own = -1;
        else if (ackc == TIMEOUT) begin m_mask[m_own] = 1'b1; m_own = -1; end
        else m_age++;
      end else if (e != 2'b00) begin
        g = (e == 2'b11) ? 1 - m_last : (e[1] ? 1 : 0);
        m_own = g; m_last = g; m_owner = g[0]; m_age = 0;
        m_addr = g ? addr1 : addr0;
        m_data = g ? data1 : data0;
        m_inv  = (int'(m_addr) >= IO_PORTS);
      end
      for (int i = 0; i < 2; i++) if (!r[i]) m_mask[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit ew, ea0, ea1;
    if (reset === 1'b1) begin
      ew  = (m_own >= 0) && !m_inv && (m_age == 0);
      ea0 = (m_own == 0) && !ew;
      ea1 = (m_own == 1) && !ew;
      chk("busy", busy, m_own >= 0);
      chk("io_writemem", io_writemem, ew);
      chk("ack0", ack0, ea0);
      chk("ack1", ack1, ea1);
      chk("err0", err0, ea0 && m_inv);
      chk("err1", err1, ea1 && m_inv);
      chk("owner", owner, m_owner);
      chk("io_address", io_address, m_addr);
      chk("io_data", io_data, m_data);
      chk("ack_exclusive", ack0 & ack1, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_wm", io_writemem, 0);
    chk("rst_ack", {ack1, ack0, err1, err0}, 0);
    chk("rst_addr", io_address, 0);
    chk("rst_data", io_data, 0);
    chk("rst_owner", owner, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic settle();
    req0 = 1'b0; req1 = 1'b0;
    for (int n = 0; n < 40 && busy; n++) @(negedge clk);
    @(negedge clk);
    chk("settle_idle", busy, 0);
  endtask

  task automatic rnd_step(input logic rq, input logic ak, input logic [7:0] a, input logic [7:0] d,
                          output logic rq_o, output logic [7:0] a_o, output logic [7:0] d_o);
    rq_o = rq; a_o = a; d_o = d;
    if (!rq) begin
      if ($urandom_range(0, 99) < 30) begin
        rq_o = 1'b1;
        a_o  = ($urandom_range(0, 9) < 8) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
        d_o  = 8'($urandom);
      end
    end else if (ak) begin
      if ($urandom_range(0, 99) < 60) rq_o = 1'b0;
    end else if ($urandom_range(0, 99) < 3) begin
      rq_o = 1'b0;
    end else if ($urandom_range(0, 99) < 10) begin
      a_o = 8'($urandom_range(0, 2));
      d_o = 8'($urandom);
    end
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int n;
    int q[$];
    vectors = 0; miscompares = 0;
    reset = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    do_reset();

    // Basic single write and latency
    req0 = 1'b1; addr0 = 8'h01; data0 = 8'hA5;
    @(negedge clk);
    chk("t1_wm", io_writemem, 1);
    chk("t1_addr", io_address, 8'h01);
    chk("t1_data", io_data, 8'hA5);
    chk("t1_ack_early", ack0, 0);
    @(negedge clk);
    chk("t1_ack", ack0, 1);
    chk("t1_wm_off", io_writemem, 0);
    req0 = 1'b0;
    @(negedge clk);
    chk("t1_ack_drop", ack0, 0);
    chk("t1_busy", busy, 0);
    settle();

    // Tie after reset, then alternation under continuous requests
    do_reset();
    addr0 = 8'h00; data0 = 8'h11; addr1 = 8'h01; data1 = 8'h22;
    req0 = 1'b1; req1 = 1'b1;
    for (int c = 0; c < 80 && q.size() < 4; c++) begin
      @(negedge clk);
      if (io_writemem) q.push_back(int'(owner));
      if (ack0) req0 = 1'b0; else if (!req0) req0 = 1'b1;
      if (ack1) req1 = 1'b0; else if (!req1) req1 = 1'b1;
    end
    chk("alt_count", q.size(), 4);
    if (q.size() >= 4) begin
      chk("alt_0", q[0], 0);
      chk("alt_1", q[1], 1);
      chk("alt_2", q[2], 0);
      chk("alt_3", q[3], 1);
    end
    settle();

    // Invalid address: no strobe, ack and err together
    req1 = 1'b1; addr1 = 8'h07; data1 = 8'h5A;
    @(negedge clk);
    chk("inv_wm", io_writemem, 0);
    chk("inv_ack", ack1, 1);
    chk("inv_err", err1, 1);
    @(negedge clk);
    chk("inv_wm2", io_writemem, 0);
    chk("inv_err2", err1, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("inv_drop", {ack1, err1}, 0);
    settle();

    // Stuck request times out, is masked, other side is still served
    req0 = 1'b1; addr0 = 8'h00; data0 = 8'h77;
    for (n = 0; n < 10 && !ack0; n++) @(negedge clk);
    chk("to_ack_seen", ack0, 1);
    req1 = 1'b1; addr1 = 8'h01; data1 = 8'h88;
    for (n = 0; n < 100 && ack0; n++) @(negedge clk);
    chk("to_ack_cycles", n, TIMEOUT);
    for (n = 0; n < 10 && !ack1; n++) @(negedge clk);
    chk("to_req1_served", ack1, 1);
    req1 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_no_regrant", busy, 0);
    end
    req0 = 1'b0;
    @(negedge clk);
    req0 = 1'b1;
    for (n = 0; n < 10 && !ack0; n++) @(negedge clk);
    chk("to_regrant", ack0, 1);
    settle();

    // Inputs changed after the grant edge are ignored
    req0 = 1'b1; addr0 = 8'h00; data0 = 8'h3C;
    @(negedge clk);
    chk("lat_wm", io_writemem, 1);
    addr0 = 8'h01; data0 = 8'hC3;
    @(negedge clk);
    chk("lat_addr", io_address, 8'h00);
    chk("lat_data", io_data, 8'h3C);
    settle();

    // Reset during the WRITE cycle aborts immediately
    req0 = 1'b1; addr0 = 8'h01; data0 = 8'h99;
    @(negedge clk);
    chk("rw_wm", io_writemem, 1);
    #2 reset = 1'b0;
    #1;
    chk("rw_wm_off", io_writemem, 0);
    chk("rw_ack", ack0, 0);
    chk("rw_busy", busy, 0);
    req0 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; addr0 = 8'h00; addr1 = 8'h01;
    @(negedge clk);
    chk("rw_tie_owner", owner, 0);
    chk("rw_tie_wm", io_writemem, 1);
    settle();

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rnd_step(req0, ack0, addr0, data0, req0, addr0, data0);
      rnd_step(req1, ack1, addr1, data1, req1, addr1, data1);
    end
    settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
